key_press_classifier: RTL and testbench

Conditions one raw, active-low board push-button (KEYn) into clean synchronous events for the calculator and buzzer stages downstream. It synchronises the key to FPGA_CLK and debounces it both ways. It classifies each press as short or long, and generates auto-repeat pulses while a long press is held. One instance per key sits between the board pins and the counter/buzzer logic, replacing edge-clocked key handling with single-clock-domain pulses.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_press_classifier_if.sv | 26 ++
 rtl/key_sync.sv | 24 ++
 rtl/key_press_classifier.sv | 143 ++++++++++++++
 tb/tb_key_press_classifier.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing constants for the push-button conditioning blocks.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      LONG_HELD,
      DEB_RELEASE
   } key_state_t;

   localparam int TICKS_20MS  = 1_000_000;
   localparam int TICKS_1S    = 50_000_000;
   localparam int TICKS_250MS = 12_500_000;
   localparam int KEY_CNT_W   = 26;

endpackage

// File: rtl/key_press_classifier_if.sv
// Key-side signal bundle: raw active-low button in, debounced level and event pulses out.
interface key_press_classifier_if;

   logic key_n;
   logic pressed;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;

   modport slave (
      input  key_n,
      output pressed,
      output short_pulse,
      output long_pulse,
      output repeat_pulse
   );

   modport master (
      output key_n,
      input  pressed,
      input  short_pulse,
      input  long_pulse,
      input  repeat_pulse
   );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous board input; resets to 1 (released/inactive).
module key_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/key_press_classifier.sv
// Debounces one active-low key and classifies presses into short, long and auto-repeat pulses.
module key_press_classifier
   import key_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = TICKS_20MS,
   parameter int LONG_TICKS     = TICKS_1S,
   parameter int REPEAT_TICKS   = TICKS_250MS,
   parameter int CNT_W          = KEY_CNT_W
) (
   input  logic                   FPGA_CLK,
   input  logic                   RESET_BUT,
   key_press_classifier_if.slave  key_bus
);

   localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

   if (DEBOUNCE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1 ||
       longint'(DEBOUNCE_TICKS) > CNT_MAX || longint'(LONG_TICKS) > CNT_MAX ||
       longint'(REPEAT_TICKS) > CNT_MAX) begin : g_bad_cnt_w
      $error("key_press_classifier: CNT_W too small or tick parameter below 1");
   end

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             w_key_s;
   key_state_t       r_state,    w_state_nxt;
   logic [CNT_W-1:0] r_deb_cnt,  w_deb_nxt;
   logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
   logic [CNT_W-1:0] r_rep_cnt,  w_rep_nxt;
   logic             r_was_long, w_was_long_nxt;
   logic             r_pressed,  w_pressed_nxt;
   logic             r_short,    w_short_nxt;
   logic             r_long,     w_long_nxt;
   logic             r_repeat,   w_repeat_nxt;

   key_sync u_sync (
      .i_clk   (FPGA_CLK),
      .i_rst_n (RESET_BUT),
      .i_async (key_bus.key_n),
      .o_sync  (w_key_s)
   );

   always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
      if (!RESET_BUT) begin
         r_state    <= IDLE;
         r_deb_cnt  <= '0;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         r_was_long <= 1'b0;
         r_pressed  <= 1'b0;
         r_short    <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_deb_cnt  <= w_deb_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rep_cnt  <= w_rep_nxt;
         r_was_long <= w_was_long_nxt;
         r_pressed  <= w_pressed_nxt;
         r_short    <= w_short_nxt;
         r_long     <= w_long_nxt;
         r_repeat   <= w_repeat_nxt;
      end
   end

   // A high key_s in either held state wins over the hold/repeat count, so counters freeze.
   always_comb begin
      w_state_nxt    = r_state;
      w_deb_nxt      = r_deb_cnt;
      w_hold_nxt     = r_hold_cnt;
      w_rep_nxt      = r_rep_cnt;
      w_was_long_nxt = r_was_long;
      w_short_nxt    = 1'b0;
      w_long_nxt     = 1'b0;
      w_repeat_nxt   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_key_s) begin
               w_state_nxt = DEB_PRESS;
               w_deb_nxt   = '0;
            end
         end
         DEB_PRESS: begin
            if (w_key_s) begin
               w_state_nxt = IDLE;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_state_nxt    = HELD;
               w_hold_nxt     = '0;
               w_was_long_nxt = 1'b0;
            end else begin
               w_deb_nxt = r_deb_cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (w_key_s) begin
               w_state_nxt = DEB_RELEASE;
               w_deb_nxt   = '0;
            end else if (r_hold_cnt == LONG_LAST) begin
               w_state_nxt    = LONG_HELD;
               w_long_nxt     = 1'b1;
               w_rep_nxt      = '0;
               w_was_long_nxt = 1'b1;
            end else begin
               w_hold_nxt = r_hold_cnt + CNT_ONE;
            end
         end
         LONG_HELD: begin
            if (w_key_s) begin
               w_state_nxt = DEB_RELEASE;
               w_deb_nxt   = '0;
            end else if (r_rep_cnt == REP_LAST) begin
               w_repeat_nxt = 1'b1;
               w_rep_nxt    = '0;
            end else begin
               w_rep_nxt = r_rep_cnt + CNT_ONE;
            end
         end
         DEB_RELEASE: begin
            if (!w_key_s) begin
               w_state_nxt = r_was_long ? LONG_HELD : HELD;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_state_nxt = IDLE;
               w_short_nxt = !r_was_long;
            end else begin
               w_deb_nxt = r_deb_cnt + CNT_ONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_pressed_nxt = (w_state_nxt == HELD) || (w_state_nxt == LONG_HELD) ||
                      (w_state_nxt == DEB_RELEASE);
   end

   assign key_bus.pressed      = r_pressed;
   assign key_bus.short_pulse  = r_short;
   assign key_bus.long_pulse   = r_long;
   assign key_bus.repeat_pulse = r_repeat;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised and directed checks of key_press_classifier against a run-length reference model.
module tb_key_press_classifier;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 8;

   logic FPGA_CLK = 1'b0;
   logic RESET_BUT;

   key_press_classifier_if kif ();

   key_press_classifier #(
      .DEBOUNCE_TICKS (D),
      .LONG_TICKS     (L),
      .REPEAT_TICKS   (R),
      .CNT_W          (8)
   ) dut (
      .FPGA_CLK  (FPGA_CLK),
      .RESET_BUT (RESET_BUT),
      .key_bus   (kif)
   );

   always #5 FPGA_CLK = ~FPGA_CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: key delayed two samples; accepted level flips after D+1 consecutive
   // disagreeing samples; hold/repeat advance only on agreeing samples with no pending run.
   bit m_d0, m_d1;
   bit m_p, m_s, m_l, m_r, m_wl;
   int m_run, m_hold, m_repc;

   task automatic model_reset();
      m_d0 = 1'b1; m_d1 = 1'b1;
      m_p = 1'b0; m_s = 1'b0; m_l = 1'b0; m_r = 1'b0; m_wl = 1'b0;
      m_run = 0; m_hold = 0; m_repc = 0;
   endtask

   task automatic model_edge(input bit k);
      bit ks;
      ks = m_d1;
      m_s = 1'b0; m_l = 1'b0; m_r = 1'b0;
      if (ks == m_p) begin
         m_run++;
         if (m_run == D + 1) begin
            if (m_p && !m_wl) m_s = 1'b1;
            m_p   = !m_p;
            m_run = 0;
            if (m_p) begin
               m_hold = 0; m_repc = 0; m_wl = 1'b0;
            end
         end
      end else begin
         if (m_p && m_run == 0) begin
            if (!m_wl) begin
               m_hold++;
               if (m_hold == L) begin
                  m_l = 1'b1; m_wl = 1'b1; m_repc = 0;
               end
            end else begin
               m_repc++;
               if (m_repc == R) begin
                  m_r = 1'b1; m_repc = 0;
               end
            end
         end
         m_run = 0;
      end
      m_d1 = m_d0;
      m_d0 = k;
   endtask

   int sc_i, t_rise, t_fall, t_short, t_long, n_short, n_long, n_pr;
   int t_rep[$];

   task automatic scen_start();
      sc_i = 0; t_rise = -1; t_fall = -1; t_short = -1; t_long = -1;
      n_short = 0; n_long = 0; n_pr = 0;
      t_rep.delete();
   endtask

   task automatic cyc(input bit k);
      logic [3:0] obs, exp;
      kif.key_n = k;
      @(posedge FPGA_CLK);
      model_edge(k);
      #1;
      obs = {kif.pressed, kif.short_pulse, kif.long_pulse, kif.repeat_pulse};
      exp = {m_p, m_s, m_l, m_r};
      chk("outs", int'(obs), int'(exp));
      chk("excl", int'($countones(obs[2:0]) <= 1), 1);
      if (obs[3]) n_pr++;
      if (obs[3] && t_rise < 0) t_rise = sc_i;
      if (!obs[3] && t_rise >= 0 && t_fall < 0) t_fall = sc_i;
      if (obs[2]) begin
         n_short++;
         if (t_short < 0) t_short = sc_i;
      end
      if (obs[1]) begin
         n_long++;
         if (t_long < 0) t_long = sc_i;
      end
      if (obs[0]) t_rep.push_back(sc_i);
      sc_i++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
   endtask

   initial begin
      bit lvl;
      int len;
      RESET_BUT = 1'b0;
      kif.key_n = 1'b1;
      model_reset();
      scen_start();
      repeat (3) @(posedge FPGA_CLK);
      #1;
      chk("reset_outs", int'({kif.pressed, kif.short_pulse, kif.long_pulse, kif.repeat_pulse}), 0);
      @(negedge FPGA_CLK);
      RESET_BUT = 1'b1;
      idle(5);

      // clean short press
      scen_start();
      for (int i = 0; i < 10; i++) cyc(1'b0);
      idle(15);
      chk("short_rise", t_rise, 6);
      chk("short_fall", t_fall, 16);
      chk("short_at", t_short, 16);
      chk("short_cnt", n_short, 1);
      chk("short_nolong", n_long + t_rep.size(), 0);

      // bounce on press
      scen_start();
      cyc(1'b0); cyc(1'b0); cyc(1'b1);
      for (int i = 0; i < 12; i++) cyc(1'b0);
      idle(15);
      chk("bounce_rise", t_rise, 9);

      // long press with repeat
      scen_start();
      for (int i = 0; i <= 50; i++) cyc(1'b0);
      idle(15);
      chk("long_rise", t_rise, 6);
      chk("long_at", t_long, 26);
      chk("rep0_at", (t_rep.size() > 0) ? t_rep[0] : -1, 34);
      chk("rep1_at", (t_rep.size() > 1) ? t_rep[1] : -1, 42);
      chk("long_fall", t_fall, 57);
      chk("long_noshort", n_short, 0);

      // release bounce during HELD: three frozen cycles delay long_pulse
      scen_start();
      for (int i = 0; i < 10; i++) cyc(1'b0);
      cyc(1'b1); cyc(1'b1);
      for (int i = 0; i < 30; i++) cyc(1'b0);
      idle(15);
      chk("relb_fall", t_fall, 48);
      chk("relb_long", t_long, 29);
      chk("relb_noshort", n_short, 0);

      // glitch rejection
      scen_start();
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0); cyc(1'b1); cyc(1'b1);
      end
      chk("glitch_pressed", n_pr, 0);
      chk("glitch_pulses", n_short + n_long + t_rep.size(), 0);

      // reset mid LONG_HELD, then release with key still held
      scen_start();
      for (int i = 0; i < 30; i++) cyc(1'b0);
      #2;
      RESET_BUT = 1'b0;
      #1;
      chk("rst_async", int'({kif.pressed, kif.short_pulse, kif.long_pulse, kif.repeat_pulse}), 0);
      model_reset();
      repeat (2) @(posedge FPGA_CLK);
      #1;
      chk("rst_hold", int'({kif.pressed, kif.short_pulse, kif.long_pulse, kif.repeat_pulse}), 0);
      @(negedge FPGA_CLK);
      RESET_BUT = 1'b1;
      scen_start();
      for (int i = 0; i < 30; i++) cyc(1'b0);
      idle(15);
      chk("rst_rise", t_rise, 6);
      chk("rst_long", t_long, 26);
      chk("rst_noshort", n_short, 0);

      // random bouncy key activity
      scen_start();
      for (int s = 0; s < 60; s++) begin
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
         else len = $urandom_range(4, 45);
         for (int j = 0; j < len; j++) cyc(lvl);
      end
      idle(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
